// File: rtl/timer_scheduler.sv
// Shared 1-second time base with N_SLOTS one-shot countdown slots and expiry pulses.
// Optional feature macro: TIMER_SCHED_PAUSE_EN adds i_pause, which freezes the time base.
module timer_scheduler #(
    parameter int TIMER_WIDTH = 16,
    parameter int CLK_FREQ    = 100_000_000,
    parameter int N_SLOTS     = 4,
    localparam int SW         = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_arm_valid,
    input  logic [SW-1:0]          i_arm_slot,
    input  logic [TIMER_WIDTH-1:0] i_arm_secs,
    output logic                   o_arm_ready,
    input  logic                   i_cancel_valid,
    input  logic [SW-1:0]          i_cancel_slot,
    output logic [N_SLOTS-1:0]     o_active,
    output logic [N_SLOTS-1:0]     o_expired,
    output logic                   o_tick,
    output logic [TIMER_WIDTH-1:0] o_current_time
`ifdef TIMER_SCHED_PAUSE_EN
    ,
    input  logic                   i_pause
`endif
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_FREQ - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } slot_state_t;

    logic                   pause;
    logic                   tick_int;
    logic [PW-1:0]          prescaler_q, prescaler_d;
    logic [TIMER_WIDTH-1:0] time_q, time_d;
    logic                   tick_q;
    logic [N_SLOTS-1:0]     arm_sel, cancel_sel;
    logic [N_SLOTS-1:0]     arm_hit, cancel_hit;

`ifdef TIMER_SCHED_PAUSE_EN
    assign pause = i_pause;
`else
    assign pause = 1'b0;
`endif

    // Time base: the prescaler simply holds while paused, so release resumes mid-second.
    always_comb begin
        tick_int    = !pause && (prescaler_q == PRE_MAX);
        prescaler_d = prescaler_q;
        time_d      = time_q;
        if (!pause) begin
            prescaler_d = tick_int ? '0 : prescaler_q + PW'(1);
        end
        if (tick_int) begin
            time_d = time_q + TIMER_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q <= '0;
            time_q      <= '0;
            tick_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            time_q      <= time_d;
            tick_q      <= tick_int;
        end
    end

    assign o_tick         = tick_q;
    assign o_current_time = time_q;

    // Slot decode; an out-of-range slot number matches no bit, so it is never ready
    // and its cancel reaches nobody.
    always_comb begin
        arm_sel    = '0;
        cancel_sel = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            arm_sel[k]    = (i_arm_slot == SW'(k));
            cancel_sel[k] = (i_cancel_slot == SW'(k));
        end
    end

    // Handshake: o_arm_ready depends only on the addressed slot being idle;
    // a transfer happens in any cycle where i_arm_valid and o_arm_ready are both high.
    assign o_arm_ready = |(arm_sel & ~o_active);
    assign arm_hit     = {N_SLOTS{i_arm_valid & o_arm_ready}} & arm_sel;
    assign cancel_hit  = {N_SLOTS{i_cancel_valid}} & cancel_sel;

    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        slot_state_t            state_q;
        logic [TIMER_WIDTH-1:0] remaining_q;
        logic                   expired_q;

        // Cancel beats a same-cycle expiry; an arm is only possible while idle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q     <= S_IDLE;
                remaining_q <= '0;
                expired_q   <= 1'b0;
            end else begin
                expired_q <= 1'b0;
                case (state_q)
                    S_IDLE: begin
                        if (arm_hit[k]) begin
                            if (i_arm_secs != '0) begin
                                state_q     <= S_ARMED;
                                remaining_q <= i_arm_secs;
                            end else begin
                                expired_q <= 1'b1;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (cancel_hit[k]) begin
                            state_q     <= S_IDLE;
                            remaining_q <= '0;
                        end else if (tick_int) begin
                            if (remaining_q == TIMER_WIDTH'(1)) begin
                                state_q     <= S_IDLE;
                                remaining_q <= '0;
                                expired_q   <= 1'b1;
                            end else begin
                                remaining_q <= remaining_q - TIMER_WIDTH'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end

        // The active vector is the per-slot FSM state itself.
        assign o_active[k]  = (state_q == S_ARMED);
        assign o_expired[k] = expired_q;
    end

endmodule
